// File: rtl/ef_pwm32_pkg.sv
// Shared definitions for the PWM dead-time channel: state encoding and default widths.
package ef_pwm32_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HI_ON   = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_FAULT   = 3'd5
  } pwm_state_e;

  function automatic logic is_dead_time(input pwm_state_e st);
    return (st == ST_DT_RISE) || (st == ST_DT_FALL);
  endfunction

endpackage

// File: rtl/ef_pwm32_sync.sv
// N-flop synchronizer for asynchronous trip inputs; flops reset to the inactive level 0.
module ef_pwm32_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/ef_pwm32_deadtime.sv
// Complementary gate-drive stage: dead-time insertion, short-pulse swallowing and sticky fault trip.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | stage disabled or just cleared, both drives off
// LO_ON      | low-side drive on
// DT_RISE    | dead time before high side, both off, counter running
// HI_ON      | high-side drive on
// DT_FALL    | dead time before low side, both off, counter running
// FAULT      | latched trip, both off until fault_clr with fault gone
module ef_pwm32_deadtime
  import ef_pwm32_pkg::*;
#(
  parameter int DT_W        = DT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_in,
  input  logic            en,
  input  logic [DT_W-1:0] rise_dly,
  input  logic [DT_W-1:0] fall_dly,
  input  logic            fault_in,
  input  logic            fault_pol,
  input  logic            fault_clr,
  output logic            out_hi,
  output logic            out_lo,
  output logic            fault_sts,
  output logic            dt_busy
);

  pwm_state_e      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_q;
  logic            out_hi_q, out_hi_d;
  logic            out_lo_q, out_lo_d;
  logic            fault_sts_q, fault_sts_d;
  logic            dt_busy_q, dt_busy_d;
  logic            fault_sync;
  logic            fault_act;

  ef_pwm32_sync #(
    .N (SYNC_STAGES)
  ) u_fault_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fault_in),
    .q     (fault_sync)
  );

  assign fault_act = fault_sync ^ ~fault_pol;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_act) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) state_d = ST_IDLE;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A zero delay skips the dead-time state entirely.
          if (pwm_q) begin
            if (rise_dly == '0) state_d = ST_HI_ON;
            else begin
              state_d = ST_DT_RISE;
              cnt_d   = rise_dly;
            end
          end else begin
            if (fall_dly == '0) state_d = ST_LO_ON;
            else begin
              state_d = ST_DT_FALL;
              cnt_d   = fall_dly;
            end
          end
        end
        ST_LO_ON: begin
          if (pwm_q) begin
            if (rise_dly == '0) state_d = ST_HI_ON;
            else begin
              state_d = ST_DT_RISE;
              cnt_d   = rise_dly;
            end
          end
        end
        ST_DT_RISE: begin
          if (!pwm_q)                  state_d = ST_LO_ON;
          else if (cnt_q == DT_W'(1))  state_d = ST_HI_ON;
          else                         cnt_d   = cnt_q - DT_W'(1);
        end
        ST_HI_ON: begin
          if (!pwm_q) begin
            if (fall_dly == '0) state_d = ST_LO_ON;
            else begin
              state_d = ST_DT_FALL;
              cnt_d   = fall_dly;
            end
          end
        end
        ST_DT_FALL: begin
          if (pwm_q)                   state_d = ST_HI_ON;
          else if (cnt_q == DT_W'(1))  state_d = ST_LO_ON;
          else                         cnt_d   = cnt_q - DT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the next state so they move on the same edge as the state.
    out_hi_d    = (state_d == ST_HI_ON);
    out_lo_d    = (state_d == ST_LO_ON);
    fault_sts_d = (state_d == ST_FAULT);
    dt_busy_d   = is_dead_time(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pwm_q       <= 1'b0;
      out_hi_q    <= 1'b0;
      out_lo_q    <= 1'b0;
      fault_sts_q <= 1'b0;
      dt_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_in;
      out_hi_q    <= out_hi_d;
      out_lo_q    <= out_lo_d;
      fault_sts_q <= fault_sts_d;
      dt_busy_q   <= dt_busy_d;
    end
  end

  assign out_hi    = out_hi_q;
  assign out_lo    = out_lo_q;
  assign fault_sts = fault_sts_q;
  assign dt_busy   = dt_busy_q;

endmodule

// File: tb/tb_ef_pwm32_deadtime.sv
// Directed bench for the dead-time stage, with an overlap and dead-time length monitor.
module tb_ef_pwm32_deadtime;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       en = 1'b0;
  logic [7:0] rise_dly = '0;
  logic [7:0] fall_dly = '0;
  logic       fault_in = 1'b0;
  logic       fault_pol = 1'b1;
  logic       fault_clr = 1'b0;
  logic       out_hi, out_lo, fault_sts, dt_busy;
  logic [3:0] obs;

  int errors = 0;
  int checks = 0;
  int gap_checks = 0;

  always #5 clk = ~clk;

  ef_pwm32_deadtime #(.DT_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .en        (en),
    .rise_dly  (rise_dly),
    .fall_dly  (fall_dly),
    .fault_in  (fault_in),
    .fault_pol (fault_pol),
    .fault_clr (fault_clr),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .fault_sts (fault_sts),
    .dt_busy   (dt_busy)
  );

  assign obs = {out_hi, out_lo, dt_busy, fault_sts};

  // Delay values present at each active edge, i.e. what the DUT loads on that edge.
  logic [7:0] rise_smp, fall_smp;
  always @(posedge clk) begin
    rise_smp = rise_dly;
    fall_smp = fall_dly;
  end

  // Overlap monitor plus measurement of every completed dead-time gap.
  logic prev_hi = 1'b0, prev_lo = 1'b0, gap_act = 1'b0, gap_from_lo = 1'b0;
  int   gap_len = 0, gap_dly = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      gap_act = 1'b0;
      prev_hi = 1'b0;
      prev_lo = 1'b0;
    end else begin
      checks++;
      if (out_hi && out_lo) begin
        errors++;
        $display("FAIL overlap: out_hi=%b out_lo=%b at %0t, want never both 1", out_hi, out_lo, $time);
      end
      if (gap_act) begin
        if (out_hi || out_lo) begin
          if ((gap_from_lo && out_hi) || (!gap_from_lo && out_lo)) begin
            checks++;
            gap_checks++;
            if (gap_len != gap_dly) begin
              errors++;
              $display("FAIL dead_time_len: measured %0d cycles, want %0d at %0t", gap_len, gap_dly, $time);
            end
          end
          gap_act = 1'b0;
        end else if (!dt_busy) begin
          gap_act = 1'b0;
        end else begin
          gap_len++;
        end
      end
      if (!gap_act && !out_hi && !out_lo && dt_busy && (prev_lo || prev_hi)) begin
        gap_act     = 1'b1;
        gap_from_lo = prev_lo;
        gap_dly     = prev_lo ? int'(rise_smp) : int'(fall_smp);
        gap_len     = 1;
      end
      prev_hi = out_hi;
      prev_lo = out_lo;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0; fault_in = 1'b0;
    fault_pol = 1'b1; fault_clr = 1'b0; rise_dly = '0; fall_dly = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_held: hi/lo/busy/sts=%b want 0000", obs); end
    apply_reset();
    tick(3);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_en0_idle: hi/lo/busy/sts=%b want 0000", obs); end
  endtask

  task automatic test_dead_time();
    logic [3:0] exp;
    apply_reset();
    rise_dly = 8'd4; fall_dly = 8'd6; en = 1'b1;
    tick(10);
    checks++;
    if (obs !== 4'b0100) begin errors++; $display("FAIL dt_settle: hi/lo/busy/sts=%b want 0100", obs); end
    pwm_in = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      exp = (i < 2) ? 4'b0100 : (i < 6) ? 4'b0010 : 4'b1000;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dt_rise cyc %0d: hi/lo/busy/sts=%b want %b", i, obs, exp); end
    end
    pwm_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i < 2) ? 4'b1000 : (i < 8) ? 4'b0010 : 4'b0100;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dt_fall cyc %0d: hi/lo/busy/sts=%b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_zero_dt();
    logic [3:0] exp;
    logic       prev;
    apply_reset();
    en = 1'b1;
    tick(3);
    checks++;
    if (obs !== 4'b0100) begin errors++; $display("FAIL zdt_settle: hi/lo/busy/sts=%b want 0100", obs); end
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pwm_in = (((i / 5) % 2) == 1);
      tick();
      exp = prev ? 4'b1000 : 4'b0100;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL zdt cyc %0d: hi/lo/busy/sts=%b want %b", i, obs, exp); end
      prev = pwm_in;
    end
  endtask

  task automatic test_swallow();
    logic [3:0] exp;
    apply_reset();
    rise_dly = 8'd8; en = 1'b1;
    tick(3);
    pwm_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) pwm_in = 1'b0;
      tick();
      exp = (i >= 2 && i <= 4) ? 4'b0010 : 4'b0100;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL swallow cyc %0d: hi/lo/busy/sts=%b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_fault();
    logic [3:0] exp;
    apply_reset();
    rise_dly = 8'd2; fall_dly = 8'd2; en = 1'b1; pwm_in = 1'b1;
    tick(8);
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL fault_pre_hi: hi/lo/busy/sts=%b want 1000", obs); end
    fault_in = 1'b1;
    tick(2);
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL fault_sync_lag: hi/lo/busy/sts=%b want 1000", obs); end
    tick();
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL fault_trip: hi/lo/busy/sts=%b want 0001", obs); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL fault_clr_active: hi/lo/busy/sts=%b want 0001", obs); end
    en = 1'b0;
    tick(2);
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL fault_en_ignored: hi/lo/busy/sts=%b want 0001", obs); end
    en = 1'b1; fault_in = 1'b0;
    tick(3);
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL fault_sticky: hi/lo/busy/sts=%b want 0001", obs); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL fault_clear_idle: hi/lo/busy/sts=%b want 0000", obs); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = (i < 3) ? 4'b0010 : 4'b1000;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fault_resume cyc %0d: hi/lo/busy/sts=%b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    rise_dly = 8'd8; en = 1'b1;
    tick(3);
    pwm_in = 1'b1;
    tick(3);
    checks++;
    if (obs !== 4'b0010) begin errors++; $display("FAIL en_in_dt: hi/lo/busy/sts=%b want 0010", obs); end
    en = 1'b0;
    tick();
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL en_drop_idle: hi/lo/busy/sts=%b want 0000", obs); end
    en = 1'b1;
    tick();
    checks++;
    if (obs !== 4'b0010) begin errors++; $display("FAIL en_resume: hi/lo/busy/sts=%b want 0010", obs); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rise_dly = 8'd1; fall_dly = 8'd1; en = 1'b1; pwm_in = 1'b1;
    tick(6);
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL arst_pre_hi: hi/lo/busy/sts=%b want 1000", obs); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL arst_immediate: hi/lo/busy/sts=%b want 0000", obs); end
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_soak();
    apply_reset();
    en = 1'b1;
    gap_checks = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 60) == 0) rise_dly = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 60) == 0) fall_dly = 8'($urandom_range(0, 9));
      en = ($urandom_range(0, 150) != 0);
      if (!fault_in && $urandom_range(0, 400) == 0) fault_in = 1'b1;
      else if (fault_in && $urandom_range(0, 3) == 0) fault_in = 1'b0;
      fault_clr = !fault_in && fault_sts && ($urandom_range(0, 2) == 0);
      tick();
    end
    fault_clr = 1'b0;
    checks++;
    if (gap_checks < 20) begin errors++; $display("FAIL soak_gap_count: measured %0d gaps, want at least 20", gap_checks); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dead_time();
    test_zero_dt();
    test_swallow();
    test_fault();
    test_enable();
    test_async_reset();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
